// File: rtl/wordcell_mem_ctrl_pkg.sv
// Shared types and defaults for the Wordcell RAM controller and its arbiter.
package wordcell_mem_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } grant_t;

endpackage

// File: rtl/wordcell_mem_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; the last-grant pointer advances only when en pulses.
module rr_arbiter2
    import wordcell_mem_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_a,
    input  logic   req_b,
    input  logic   en,
    input  grant_t done_id,
    output logic   gnt_a,
    output logic   gnt_b
);

    grant_t last;

    // Reset to "B last" so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            last <= REQ_B;
        else if (en)
            last <= done_id;
    end

    always_comb begin
        gnt_a = req_a & (~req_b | (last == REQ_B));
        gnt_b = req_b & ~gnt_a;
    end

endmodule

// File: rtl/wordcell_mem_ctrl.sv
// Sequences a Wordcell row array for two round-robin requesters with bus-before-select timing.
module wordcell_mem_ctrl
    import wordcell_mem_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int ACCESS_CYCLES = 1,
    localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_ack,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_ack,
    output logic [WIDTH-1:0] b_rdata,
    output logic [DEPTH-1:0] word_sel,
    output logic             arr_rw,
    output logic [WIDTH-1:0] arr_in,
    input  logic [WIDTH-1:0] arr_out,
    output logic             busy
);

    state_t           state;
    grant_t           cur;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [3:0]       cnt;
    logic             gnt_a, gnt_b;
    logic             g_we;
    logic [AW-1:0]    g_addr;
    logic [WIDTH-1:0] g_wdata;
    logic [DEPTH-1:0] sel_dec;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (a_req),
        .req_b   (b_req),
        .en      (state == S_RECOVER),
        .done_id (cur),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    always_comb begin
        g_we    = gnt_b ? b_we    : a_we;
        g_addr  = gnt_b ? b_addr  : a_addr;
        g_wdata = gnt_b ? b_wdata : a_wdata;
    end

    // Out-of-range addresses decode to no row at all.
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < DEPTH; i++)
            if (addr_q == AW'(i))
                sel_dec[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur      <= REQ_A;
            we_q     <= 1'b0;
            addr_q   <= '0;
            cnt      <= '0;
            word_sel <= '0;
            arr_rw   <= 1'b0;
            arr_in   <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            busy     <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_a || gnt_b) begin
                        cur    <= gnt_b ? REQ_B : REQ_A;
                        we_q   <= g_we;
                        addr_q <= g_addr;
                        arr_rw <= g_we;
                        arr_in <= g_we ? g_wdata : '0;
                        busy   <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    word_sel <= sel_dec;
                    cnt      <= 4'(ACCESS_CYCLES - 1);
                    state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        word_sel <= '0;
                        state    <= S_RECOVER;
                        if (cur == REQ_A) a_ack <= 1'b1;
                        else              b_ack <= 1'b1;
                        if (!we_q) begin
                            if (cur == REQ_A) a_rdata <= (|sel_dec) ? arr_out : '0;
                            else              b_rdata <= (|sel_dec) ? arr_out : '0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RECOVER: begin
                    arr_rw <= 1'b0;
                    arr_in <= '0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wordcell_mem_ctrl.sv
// Bench: two controllers (8x1-cycle and 6x3-cycle) each wrapped around a behavioural Wordcell array.
module tb_wordcell_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    logic       a_req [2], a_we [2], a_ack [2], b_req [2], b_we [2], b_ack [2];
    logic [2:0] a_addr [2], b_addr [2];
    logic [7:0] a_wdata [2], a_rdata [2], b_wdata [2], b_rdata [2];
    logic       arr_rw [2], busy [2];
    logic [7:0] arr_in [2], arr_out [2], ws [2];
    logic [7:0] ws0;
    logic [5:0] ws1;
    assign ws[0] = ws0;
    assign ws[1] = {2'b00, ws1};

    wordcell_mem_ctrl #(.WIDTH(8), .DEPTH(8), .ACCESS_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
        .word_sel(ws0), .arr_rw(arr_rw[0]), .arr_in(arr_in[0]), .arr_out(arr_out[0]),
        .busy(busy[0]));

    wordcell_mem_ctrl #(.WIDTH(8), .DEPTH(6), .ACCESS_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
        .word_sel(ws1), .arr_rw(arr_rw[1]), .arr_in(arr_in[1]), .arr_out(arr_out[1]),
        .busy(busy[1]));

    // Wordcell rows: a selected row stores in_bus while rw is high; outputs are OR-reduced.
    logic [7:0] mem0 [8];
    logic [7:0] mem1 [6];
    always @(posedge clk) begin
        for (int r = 0; r < 8; r++)
            if (mem_init) mem0[r] <= 8'hA0 + 8'(r);
            else if (ws0[r] && arr_rw[0]) mem0[r] <= arr_in[0];
        for (int r = 0; r < 6; r++)
            if (mem_init) mem1[r] <= 8'hB0 + 8'(r);
            else if (ws1[r] && arr_rw[1]) mem1[r] <= arr_in[1];
    end
    always_comb begin
        arr_out[0] = '0;
        for (int r = 0; r < 8; r++) if (ws0[r]) arr_out[0] = arr_out[0] | mem0[r];
    end
    always_comb begin
        arr_out[1] = '0;
        for (int r = 0; r < 6; r++) if (ws1[r]) arr_out[1] = arr_out[1] | mem1[r];
    end

    int total = 0, bad = 0;
    int viol = 0, both_ack = 0;
    logic [8:0] prev_bus [2];
    logic [7:0] prev_ws [2];
    logic prev_rst = 1'b1;

    // Bus/rw may only move while select is low on both sides of the change.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!prev_rst && ({arr_rw[d], arr_in[d]} != prev_bus[d]) && (ws[d] != 0 || prev_ws[d] != 0))
                viol++;
            if (a_ack[d] && b_ack[d]) both_ack++;
            prev_bus[d] = {arr_rw[d], arr_in[d]};
            prev_ws[d]  = ws[d];
        end
        prev_rst = rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input bit pb, input bit we, input logic [2:0] addr,
                        input logic [7:0] wd, output int lat, output int nsel,
                        output logic [7:0] sel, output logic [7:0] rd);
        @(negedge clk);
        if (pb) begin b_req[d] = 1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd; end
        else    begin a_req[d] = 1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd; end
        lat = 0; nsel = 0; sel = '0;
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ws[d] != 0) begin nsel++; sel = sel | ws[d]; end
            if (pb ? b_ack[d] : a_ack[d]) break;
        end
        if (pb) b_req[d] = 0; else a_req[d] = 0;
        rd = pb ? b_rdata[d] : a_rdata[d];
    endtask

    task automatic rst_pulse();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    typedef struct {
        int d; bit pb; bit we; logic [2:0] addr; logic [7:0] wd;
        int lat; int nsel; logic [7:0] sel; logic [7:0] rd;
    } vec_t;
    vec_t tv [16];

    initial begin
        int lat, nsel, a_at, b_at, na, nb, nord;
        logic [7:0] sel, rd;
        logic [3:0] ord;
        logic [7:0] sh [8];

        for (int d = 0; d < 2; d++) begin
            a_req[d] = 0; a_we[d] = 0; a_addr[d] = 0; a_wdata[d] = 0;
            b_req[d] = 0; b_we[d] = 0; b_addr[d] = 0; b_wdata[d] = 0;
        end
        tv[0]  = '{0, 0, 1, 3, 8'h55, 3, 1, 8'h08, 8'h00};
        tv[1]  = '{0, 0, 0, 3, 8'h00, 3, 1, 8'h08, 8'h55};
        tv[2]  = '{0, 0, 1, 0, 8'h01, 3, 1, 8'h01, 8'h55};
        tv[3]  = '{0, 0, 1, 7, 8'hFE, 3, 1, 8'h80, 8'h55};
        tv[4]  = '{0, 1, 0, 0, 8'h00, 3, 1, 8'h01, 8'h01};
        tv[5]  = '{0, 1, 0, 7, 8'h00, 3, 1, 8'h80, 8'hFE};
        tv[6]  = '{0, 0, 0, 5, 8'h00, 3, 1, 8'h20, 8'hA5};
        tv[7]  = '{0, 1, 1, 3, 8'h99, 3, 1, 8'h08, 8'hFE};
        tv[8]  = '{0, 0, 0, 3, 8'h00, 3, 1, 8'h08, 8'h99};
        tv[9]  = '{0, 1, 0, 6, 8'h00, 3, 1, 8'h40, 8'hA6};
        tv[10] = '{1, 0, 1, 4, 8'h3C, 5, 3, 8'h10, 8'h00};
        tv[11] = '{1, 0, 0, 4, 8'h00, 5, 3, 8'h10, 8'h3C};
        tv[12] = '{1, 0, 0, 7, 8'h00, 5, 0, 8'h00, 8'h00};
        tv[13] = '{1, 0, 1, 6, 8'hFF, 5, 0, 8'h00, 8'h00};
        tv[14] = '{1, 1, 0, 5, 8'h00, 5, 3, 8'h20, 8'hB5};
        tv[15] = '{1, 0, 0, 0, 8'h00, 5, 3, 8'h01, 8'hB0};

        repeat (2) @(negedge clk);
        rst = 0; mem_init = 0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset word_sel", ws[d], 0);
            chk("reset busy", busy[d], 0);
            chk("reset acks", {a_ack[d], b_ack[d]}, 0);
            chk("reset rdata", {a_rdata[d], b_rdata[d]}, 0);
            chk("reset bus", {arr_rw[d], arr_in[d]}, 0);
        end

        foreach (tv[i]) begin
            xfer(tv[i].d, tv[i].pb, tv[i].we, tv[i].addr, tv[i].wd, lat, nsel, sel, rd);
            chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
            chk($sformatf("vec%0d select cycles", i), nsel, tv[i].nsel);
            chk($sformatf("vec%0d select row", i), sel, tv[i].sel);
            chk($sformatf("vec%0d rdata", i), rd, tv[i].rd);
        end

        // Contention from reset: A writes 0xCC@1, B reads @1.
        rst_pulse();
        @(negedge clk);
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 1; a_wdata[0] = 8'hCC;
        b_req[0] = 1; b_we[0] = 0; b_addr[0] = 1;
        a_at = 0; b_at = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); @(negedge clk);
            if (a_ack[0]) begin a_at = k; a_req[0] = 0; end
            if (b_ack[0]) begin b_at = k; b_req[0] = 0; end
            if (a_at != 0 && b_at != 0) break;
        end
        chk("contention A ack cycle", a_at, 3);
        chk("contention B ack cycle", b_at, 7);
        chk("contention B rdata", b_rdata[0], 8'hCC);

        // Both held: grant order must alternate starting with A.
        @(negedge clk);
        a_req[0] = 1; a_we[0] = 0; a_addr[0] = 0;
        b_req[0] = 1; b_we[0] = 0; b_addr[0] = 2;
        ord = '0; nord = 0;
        for (int k = 1; k <= 40 && nord < 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (a_ack[0] || b_ack[0]) begin ord = {ord[2:0], b_ack[0]}; nord++; end
        end
        a_req[0] = 0; b_req[0] = 0;
        chk("fairness ack count", nord, 4);
        chk("fairness order", ord, 4'b0101);
        chk("fairness A rdata", a_rdata[0], 8'h01);
        chk("fairness B rdata", b_rdata[0], 8'hA2);

        // Random traffic against a shadow copy of the array.
        for (int r = 0; r < 8; r++) sh[r] = 8'hA0 + 8'(r);
        sh[0] = 8'h01; sh[7] = 8'hFE; sh[3] = 8'h99; sh[1] = 8'hCC;
        for (int i = 0; i < 200; i++) begin
            bit pb, we;
            logic [2:0] ad;
            logic [7:0] wd;
            pb = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            ad = 3'($urandom_range(0, 7)); wd = 8'($urandom);
            xfer(0, pb, we, ad, wd, lat, nsel, sel, rd);
            chk("random latency", lat, 3);
            if (we) sh[ad] = wd;
            else chk("random rdata", rd, sh[ad]);
        end

        // Reset while a write to row 5 is in ACCESS.
        @(negedge clk);
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 5; a_wdata[0] = 8'hEE;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("mid-reset in access", ws[0], 8'h20);
        rst = 1; a_req[0] = 0;
        @(posedge clk); @(negedge clk);
        chk("mid-reset word_sel", ws[0], 0);
        chk("mid-reset busy", busy[0], 0);
        chk("mid-reset ack", {a_ack[0], b_ack[0]}, 0);
        rst = 0;
        xfer(0, 0, 0, 2, 8'h00, lat, nsel, sel, rd);
        chk("post-reset read row2", rd, sh[2]);

        // A requests for a single cycle while B waits.
        rst_pulse();
        @(negedge clk);
        a_req[0] = 1; a_we[0] = 0; a_addr[0] = 3;
        b_req[0] = 1; b_we[0] = 0; b_addr[0] = 0;
        a_at = 0; b_at = 0; na = 0; nb = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) a_req[0] = 0;
            if (a_ack[0]) begin na++; if (a_at == 0) a_at = k; end
            if (b_ack[0]) begin nb++; if (b_at == 0) b_at = k; b_req[0] = 0; end
        end
        chk("drop A ack count", na, 1);
        chk("drop A ack cycle", a_at, 3);
        chk("drop A rdata", a_rdata[0], sh[3]);
        chk("drop B ack count", nb, 1);
        chk("drop B ack cycle", b_at, 7);
        chk("drop B rdata", b_rdata[0], sh[0]);

        chk("bus change while selected", viol, 0);
        chk("dual ack cycles", both_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
